// File: rtl/common_pkg.sv
// Shared UART types and frame constants.
// Contents: byte_t payload type, DATA_BITS, STOP_BITS.
package common;

  typedef logic [7:0] byte_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Ports: clk_i, reset_i (async, active high), restart_i
// (reload count to 0), bit_done_o (high in last cycle of a bit).
module uart_baud_gen #(
  parameter int CYCLES_PER_BIT = 10
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic restart_i,
  output logic bit_done_o
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_done_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || bit_done_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter pulling bytes from an upstream FIFO.
// Ports: clk_i, reset_i (async, active high), fifo_empty_i,
// fifo_read_enable_o, fifo_read_data_i, fifo_read_valid_i,
// tx_o (serial line, idle high), busy_o (high outside IDLE).
module uart_tx
  import common::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  fifo_empty_i,
  output logic  fifo_read_enable_o,
  input  byte_t fifo_read_data_i,
  input  logic  fifo_read_valid_i,
  output logic  tx_o,
  output logic  busy_o
);

  localparam int CYCLES_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if (CYCLES_PER_BIT < 2) begin : g_cpb_chk
    $error("uart_tx: CYCLES_PER_BIT must be at least 2");
  end

  if (DATA_BITS != 8 || STOP_BITS != 1) begin : g_frame_chk
    $error("uart_tx: only 8N1 framing is implemented");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } state_e;

  state_e     state_q;
  state_e     state_d;
  byte_t      shift_q;
  byte_t      shift_d;
  logic [2:0] bit_idx_q;
  logic [2:0] bit_idx_d;
  logic       tx_q;
  logic       tx_d;
  logic       busy_q;
  logic       busy_d;
  logic       ready_q;
  logic       bit_done;
  logic       restart;
  logic       rd_en;

  // ready_q holds off the first request until one edge
  // has been seen with reset released.
  assign rd_en = ready_q
              && (state_q == IDLE)
              && !fifo_empty_i;

  assign fifo_read_enable_o = rd_en;
  assign tx_o               = tx_q;
  assign busy_o             = busy_q;

  // Every state entry starts a fresh bit period.
  assign restart = (state_d != state_q);

  uart_baud_gen #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .restart_i (restart),
    .bit_done_o(bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (rd_en) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (fifo_read_valid_i) begin
          shift_d = fifo_read_data_i;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_done) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // tx_d looks one bit ahead of the shift.
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ready_q   <= 1'b1;
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, SHALL be the frequency of clk_i in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, SHALL be the serial bit rate in bits per second.
REQ-003 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_i, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-005 Port fifo_empty_i, input, 1 bit, SHALL be the upstream FIFO empty flag (registered by the FIFO).
REQ-006 Port fifo_read_enable_o, output, 1 bit, SHALL be the read request to the upstream FIFO.
REQ-007 Port fifo_read_data_i, input, 8 bits, SHALL be the FIFO read data, qualified by fifo_read_valid_i.
REQ-008 Port fifo_read_valid_i, input, 1 bit, SHALL mark fifo_read_data_i valid; it arrives one cycle after the read request.
REQ-009 Port tx_o, output, 1 bit, SHALL be the serial line, idle high.
REQ-010 Port busy_o, output, 1 bit, SHALL be high in every state except IDLE.

Function
REQ-011 CYCLES_PER_BIT SHALL be CLK_FREQ_HZ / BAUD_RATE (integer division); elaboration SHALL fail if it is less than 2.
REQ-012 The baud counter SHALL be $clog2(CYCLES_PER_BIT) bits wide, count 0..CYCLES_PER_BIT-1, and reload to 0 on every state entry.
REQ-013 States SHALL be IDLE, FETCH, START, DATA and STOP.
REQ-014 IDLE: when fifo_empty_i=0, fifo_read_enable_o SHALL be 1 for exactly that cycle, and the next state SHALL be FETCH.
REQ-015 fifo_read_enable_o SHALL never be high outside IDLE, and never for two consecutive cycles.
REQ-016 FETCH: if fifo_read_valid_i=1, the block SHALL latch fifo_read_data_i into the shift register and go to START.
REQ-017 FETCH: if fifo_read_valid_i=0 (empty race), the block SHALL return to IDLE with no frame emitted.
REQ-018 START: tx_o SHALL be 0 for exactly CYCLES_PER_BIT cycles, then the next state SHALL be DATA.
REQ-019 DATA: the block SHALL send 8 bits LSB first, each for CYCLES_PER_BIT cycles; a 3-bit bit index SHALL wrap from 7 to STOP.
REQ-020 STOP: tx_o SHALL be 1 for CYCLES_PER_BIT cycles, then the next state SHALL be IDLE.
REQ-021 Latency: with a request in cycle N, tx_o SHALL fall in cycle N+2, and a frame SHALL last 10*CYCLES_PER_BIT cycles.
REQ-022 Back-to-back: with a non-empty FIFO, the line SHALL be high for exactly 2 cycles (IDLE + FETCH) between one stop bit and the next start bit.
REQ-023 tx_o SHALL be driven from a register (glitch-free); it SHALL be 1 in IDLE and FETCH.
REQ-024 fifo_read_valid_i outside FETCH SHALL be ignored.

Reset
REQ-025 On reset_i=1 the block SHALL asynchronously enter IDLE.
REQ-026 During reset, outputs SHALL be tx_o=1, fifo_read_enable_o=0, busy_o=0, with shift register, bit index and baud counter at 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (tx_o high), and the byte SHALL be lost.
REQ-028 The first request after reset deasserts SHALL occur no earlier than the first rising edge with reset_i=0.

Structure
REQ-029 Typedef byte_t (logic [7:0]) and the UART frame constants (DATA_BITS=8, STOP_BITS=1) SHALL live in package common.
REQ-030 The state enum SHALL remain local to the module.
REQ-031 One sub-module, uart_baud_gen (baud counter with a restart input and a one-cycle bit_done output), is natural and SHALL be used.

Verification (CLK_FREQ_HZ=100_000_000, BAUD_RATE=10_000_000, so CYCLES_PER_BIT=10)
REQ-032 Single byte: FIFO holds 0xA5, request in cycle N -> tx_o=0 over N+2..N+11; then bits 1,0,1,0,0,1,0,1 at 10 cycles each; then stop high 10 cycles; busy_o low at N+102.
REQ-033 Back-to-back: FIFO holds 0x00,0xFF -> exactly 2 high cycles between the first stop bit and the second start bit; exactly two read pulses.
REQ-034 Empty race: fifo_empty_i=0 but fifo_read_valid_i=0 in FETCH -> return to IDLE, tx_o stays 1, busy_o low after 2 cycles.
REQ-035 Reset mid-frame: reset_i asserted during DATA bit 3 of 0x0F -> tx_o=1 and busy_o=0 before the next clock edge; after release with an empty FIFO, no further read pulses.
REQ-036 Idle empty: fifo_empty_i=1 for 1000 cycles -> fifo_read_enable_o never asserts, tx_o constant 1.
